// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator for the instruction ROM.
//
// Drives the ROM byte address, absorbs the ROM's one-cycle registered read
// latency and buffers fetched words in a small FIFO. The FIFO head is offered
// to the decoder as {out_pc, out_instr} over a valid/ready handshake. A
// redirect flushes all buffered and in-flight words and restarts fetch at the
// new address on the following cycle.
//
// Parameters:
//   RESET_PC       byte address of the first fetch after reset
//   DEPTH          output FIFO entries (>= 2; 2 sustains one word per cycle)
// Ports:
//   CLK            clock, rising edge
//   RST            synchronous active-high reset
//   rom_A          ROM byte address, driven straight from the fetch PC
//   rom_Q          ROM read data, valid the cycle after rom_A
//   out_valid      FIFO head is valid
//   out_ready      decoder accepts the head
//   out_instr      instruction word at the FIFO head
//   out_pc         byte address of out_instr
//   redirect_valid flush and restart fetch
//   redirect_pc    restart byte address; bits [1:0] are forced to zero
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] rom_A,
  input  logic [31:0] rom_Q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;

  logic pop;
  logic push;
  logic issue;

  function automatic ptr_t ptr_inc(ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  // Outputs
  always_comb begin
    rom_A     = fetch_pc_q;
    out_valid = (count_q != '0);
    out_pc    = pc_mem_q[rd_ptr_q];
    out_instr = instr_mem_q[rd_ptr_q];
  end

  // Handshake, capture and credit check
  always_comb begin
    int unsigned occupancy;
    pop       = out_valid & out_ready;
    // A response returning in a redirect cycle belongs to the old stream.
    push      = inflight_q & ~redirect_valid;
    // Words already owned by the FIFO or in flight, less the one leaving now,
    // must leave room for the word this issue will bring back.
    occupancy = 32'(count_q) + 32'(inflight_q);
    issue     = ~redirect_valid && (occupancy < DEPTH + 32'(pop));
  end

  // Next-state
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      // A handshake completing now is already consumed by the decoder;
      // everything else is discarded.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= rom_Q;
    end
  end

  // The credit check must make a push into a full FIFO impossible.
  push_never_overflows: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && (count_q == cnt_t'(DEPTH))));

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] rom_a, rom_q;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Second instance exercising address wrap
  logic [31:0] w_rom_a, w_rom_q;
  logic        w_out_valid, w_ready;
  logic [31:0] w_out_instr, w_out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb   [$];
  logic [63:0] w_sb [$];

  always #5 CLK = ~CLK;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .rom_A          (rom_a),
    .rom_Q          (rom_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .CLK            (CLK),
    .RST            (RST),
    .rom_A          (w_rom_a),
    .rom_Q          (w_rom_q),
    .out_valid      (w_out_valid),
    .out_ready      (w_ready),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
  );

  // ROM contents: words[i] = A000_0000 + i, one-cycle registered read
  always @(posedge CLK) begin
    rom_q   <= 32'hA000_0000 + (rom_a >> 2);
    w_rom_q <= 32'hA000_0000 + (w_rom_a >> 2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, 32'hA000_0000 + (pc >> 2)};
  endfunction

  // Monitors: every completed handshake must match the next expected word
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %h instr %h expected nothing", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("out_pc", out_pc, e[63:32]);
        chk("out_instr", out_instr, e[31:0]);
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && w_out_valid && w_ready) begin
      if (w_sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_unexpected: got pc %h expected nothing", w_out_pc);
      end else begin
        logic [63:0] e;
        e = w_sb.pop_front();
        chk("wrap_pc", w_out_pc, e[63:32]);
        chk("wrap_instr", w_out_instr, e[31:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST            = 1'b1;
    out_ready      = 1'b0;
    w_ready        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) cyc();
    @(negedge CLK);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_rom_A", rom_a, 32'h0);
    chk("rst_wrap_rom_A", w_rom_a, 32'hFFFF_FFF8);
    chk("rst_wrap_valid", {31'b0, w_out_valid}, 32'd0);

    // Cycle N: first cycle with RST low
    cyc();
    RST       = 1'b0;
    out_ready = 1'b1;
    w_ready   = 1'b1;
    for (int i = 0; i <= 8; i++) sb.push_back(ent(32'(i * 4)));
    w_sb.push_back({32'hFFFF_FFF8, 32'hDFFF_FFFE});
    w_sb.push_back({32'hFFFF_FFFC, 32'hDFFF_FFFF});
    w_sb.push_back({32'h0000_0000, 32'hA000_0000});
    @(negedge CLK);
    chk("n0_valid", {31'b0, out_valid}, 32'd0);
    chk("n0_rom_A", rom_a, 32'h0);
    cyc();
    @(negedge CLK);
    chk("n1_valid", {31'b0, out_valid}, 32'd0);
    chk("n1_rom_A", rom_a, 32'h4);

    // N+2..N+10: pcs 0..0x20 back to back; redirect in the cycle 0x20 is taken
    for (int k = 0; k <= 8; k++) begin
      cyc();
      if (k == 3) w_ready = 1'b0;
      if (k == 8) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
      end
      @(negedge CLK);
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
    end

    // R+1
    cyc();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    @(negedge CLK);
    chk("redir_rom_A", rom_a, 32'h0000_0100);
    chk("redir_r1_valid", {31'b0, out_valid}, 32'd0);
    // R+2
    cyc();
    for (int i = 0; i < 8; i++) sb.push_back(ent(32'h100 + 32'(i * 4)));
    @(negedge CLK);
    chk("redir_r2_valid", {31'b0, out_valid}, 32'd0);

    // R+3..R+12: backpressure, head and fetch address frozen
    for (int k = 0; k < 10; k++) begin
      cyc();
      @(negedge CLK);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_head_pc", out_pc, 32'h0000_0100);
      chk("bp_head_instr", out_instr, 32'hA000_0040);
      chk("bp_rom_A", rom_a, 32'h0000_0108);
    end

    // R+13..R+20: release, pcs 0x100..0x11C stream out
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) out_ready = 1'b1;
      @(negedge CLK);
      chk("resume_valid", {31'b0, out_valid}, 32'd1);
    end

    // R+21..R+22: fill the FIFO
    cyc();
    out_ready = 1'b0;
    cyc();
    @(negedge CLK);
    chk("full_rom_A", rom_a, 32'h0000_0128);
    chk("full_head_pc", out_pc, 32'h0000_0120);

    // R+23: reset pulse; synchronous, so outputs hold until the edge
    cyc();
    RST = 1'b1;
    @(negedge CLK);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);

    // R+24
    cyc();
    RST       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(ent(32'(i * 4)));
    @(negedge CLK);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_rom_A", rom_a, 32'h0);
    chk("post_rst_wrap_rom_A", w_rom_a, 32'hFFFF_FFF8);
    cyc();
    @(negedge CLK);
    chk("post_rst_valid1", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge CLK);
      chk("refetch_valid", {31'b0, out_valid}, 32'd1);
    end

    cyc();
    out_ready = 1'b0;
    repeat (3) cyc();
    @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("wrap_sb_drained", 32'(w_sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch initiator for the core's instruction ROM. It drives the ROM byte address, absorbs the ROM's one-cycle registered read latency, and buffers fetched words in a small FIFO. It presents `{pc, instr}` to the decoder over a valid/ready handshake and supports single-cycle redirects for branches and jumps. It sits between the instruction ROM (`Q <= mem[A>>2]` on every posedge, no enable) and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address of the first fetch after reset.
- `DEPTH`, 2, output FIFO entries. Minimum 2; 2 sustains one instruction per cycle.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `rom_A` output 32: byte address to the ROM; combinational from the fetch PC register.
- `rom_Q` input 32: ROM read data; valid the cycle after `rom_A` was presented.
- `out_valid` output 1: FIFO head is valid.
- `out_ready` input 1: decoder accepts the head.
- `out_instr` output 32: instruction word at the FIFO head.
- `out_pc` output 32: byte address of `out_instr`.
- `redirect_valid` input 1: flush the unit and restart fetch.
- `redirect_pc` input 32: new fetch byte address; bits [1:0] are ignored and forced to 0.

## Operation
- State:
  - `fetch_pc` (32b)
  - `inflight` (1b) plus `inflight_pc` (32b)
  - FIFO of `DEPTH` × 64b `{pc, instr}` with `count`
- `rom_A = fetch_pc` at all times. The ROM reads every cycle; `rom_Q` is captured only when `inflight` = 1.
- `pop = out_valid && out_ready`.
- Issue condition, when there is no redirect: `count + inflight - pop < DEPTH`.
- On issue:
  - `inflight` <= 1
  - `inflight_pc` <= `fetch_pc`
  - `fetch_pc` <= `fetch_pc + 4`, mod 2^32, so 32'hFFFF_FFFC wraps to 0
- No issue: `inflight` <= 0 and `fetch_pc` holds.
- Capture: if `inflight` = 1 and there is no redirect, push `{inflight_pc, rom_Q}` into the FIFO this cycle.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- The credit rule guarantees a push never hits a full FIFO. The implementation asserts this in simulation.
- Redirect has priority over issue, capture and pop. In a cycle with `redirect_valid` = 1:
  - A handshake completing in that same cycle is honored: the decoder owns that word.
  - All remaining FIFO entries are discarded; `count` <= 0.
  - `inflight` <= 0; any response returning next cycle is dropped.
  - `fetch_pc` <= `{redirect_pc[31:2], 2'b00}`.
  - No issue occurs that cycle.
- Back-to-back redirects: the last one wins; each flushes as above.
- `out_instr` and `out_pc` are FIFO head fields. They must be stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `fetch_pc` = `RESET_PC`
  - `inflight` = 0, `count` = 0
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0
  - `rom_A` = `RESET_PC`
- Reset asserted mid-operation clears everything at that edge. No partial state survives.
- Fetch latency: issue in cycle N (`rom_A` = pc), `rom_Q` valid in N+1, pushed at end of N+1, `out_valid` = 1 in N+2.
- After reset release: the first cycle with RST = 0 is N. `out_pc` = `RESET_PC` appears in N+2.
- Redirect asserted in cycle R: `rom_A` = `redirect_pc` in R+1, and the first valid output (`out_pc` = `redirect_pc`) appears in R+3. `out_valid` = 0 in R+1 and R+2.
- Throughput: with `out_ready` held high, one instruction per cycle in steady state (`count` = 1, `inflight` = 1).
- Backpressure: with `out_ready` = 0, issue stops once `count + inflight` = `DEPTH`. No ROM response is ever lost.

## Test plan
- Reset, then ROM filled with words[i] = 32'hA000_0000+i and `out_ready` = 1:
  - `out_valid` rises 2 cycles after reset release.
  - `out_pc` = 0, 4, 8, … on consecutive cycles with `out_instr` = A0000000, A0000001, …, no bubbles.
- Backpressure: `out_ready` = 0 for 10 cycles after the first valid, then 1:
  - `rom_A` stalls at 8 (`DEPTH` = 2).
  - The head holds pc 0 stable.
  - After release, pcs 0, 4, 8 … resume contiguously with no skip or duplicate.
- Redirect to 32'h0000_0103 during streaming:
  - `rom_A` = 0x100 next cycle.
  - `out_valid` = 0 for 2 cycles.
  - Next output is pc 0x100; no stale pre-redirect word is emitted.
- Redirect in the same cycle as a completing handshake (head pc 0x20):
  - pc 0x20 counts as consumed.
  - pc 0x24 (queued or in flight) is never presented.
- Wrap: `RESET_PC` = 32'hFFFF_FFF8 gives output pcs FFFFFFF8, FFFFFFFC, 00000000.
- RST pulsed for 1 cycle mid-stream with a full FIFO:
  - Next cycle `out_valid` = 0 and `rom_A` = `RESET_PC`.
  - Refetch resumes from `RESET_PC` with 2-cycle latency.
